mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised load/store bus unit that owns the Avalon memory-mapped master port of the multicycle MIPS core. It accepts one byte, half-word or word request at a time from the CPU datapath and handles byte-lane steering, endian conversion, sign/zero extension and `waitrequest` stalls. Misaligned accesses and bus timeouts are reported as errors. It replaces the fixed word-only, stall-free memory path in `mips_cpu_bus`.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width on both the CPU and bus sides.
- `BIG_ENDIAN`, default 1: 1 means the lowest byte address is the most significant byte of the CPU value; 0 means little-endian.
- `TIMEOUT_CYCLES`, default 0: maximum number of consecutive `waitrequest` cycles before the transfer is aborted; 0 disables the timeout.
- `clk`  in  1  clock; one clock domain.
- `reset_n_i`  in  1  synchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted when this and `req_valid_i` are both 1 at a rising edge.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  `mem_size_t`  byte, half or word.
- `req_signed_i`  in  1  sign-extend load result (LB/LH); ignored for word accesses and stores.
- `req_addr_i`  in  `ADDR_WIDTH`  byte address.
- `req_wdata_i`  in  32  store value, right-aligned (a byte store uses bits [7:0]).
- `resp_valid_o`  out  1  one-cycle completion pulse.
- `resp_rdata_o`  out  32  load result, extended to 32 bits; 0 for stores and errors.
- `resp_err_o`  out  1  qualifies `resp_valid_o`: misaligned access or timeout.
- `address`  out  `ADDR_WIDTH`  word-aligned bus address; bits [1:0] are always 0.
- `read`  out  1  Avalon read.
- `write`  out  1  Avalon write.
- `waitrequest`  in  1  Avalon stall.
- `writedata`  out  32  lane-steered store data.
- `byteenable`  out  4  active lanes.
- `readdata`  in  32  bus read data, valid in the cycle where `waitrequest` is 0.

## Operation
- States: IDLE, ACCESS, RESP.
- `req_ready_o` is 1 in IDLE and in RESP only.
- IDLE, or RESP, with a request accepted:
  - If aligned, latch the request and go to ACCESS.
  - If misaligned, go to RESP with `resp_err_o`=1 and issue no bus cycle.
- RESP with no request accepted goes to IDLE.
- Alignment, with offset `o = req_addr_i[1:0]`:
  - Half-word requires `o[0]`=0.
  - Word requires `o`=0.
  - Byte accesses are always aligned.
- ACCESS:
  - Drive `read` or `write`, with `address`, `byteenable` and `writedata` held stable for the whole state.
  - Leave ACCESS in the cycle where `waitrequest`=0, sampling `readdata` on that edge. Go to RESP with `resp_err_o`=0.
- Timeout: when `TIMEOUT_CYCLES`=N>0 and `waitrequest` has been 1 for N consecutive ACCESS cycles:
  - Deassert `read`/`write` on the next edge.
  - Go to RESP with `resp_err_o`=1 and `resp_rdata_o`=0.
  - The wait counter clears on entry to ACCESS.
- Lane mapping: byte at offset `o` travels on lane `o`, i.e. bits [8o+7:8o].
  - Byte: `byteenable` = 1<<o.
  - Half: `byteenable` = 4'b0011<<o.
  - Word: `byteenable` = 4'hF.
  - `BIG_ENDIAN`=1: the lane with the lower offset is the more significant byte of the value, for both loads and stores.
  - `BIG_ENDIAN`=0: the lane with the lower offset is the less significant byte.
  - Lanes that are not enabled drive 0 in `writedata`.
- Load extension:
  - Byte/half results are zero-extended, or sign-extended from bit 7 or 15 when `req_signed_i`=1.
  - Word results are unchanged.
- `resp_rdata_o` holds its value until the next response.

## Timing
- Reset (`reset_n_i`=0 at an edge), from any state:
  - State becomes IDLE.
  - `read`, `write`, `resp_valid_o`, `resp_err_o` become 0.
  - `address`, `writedata`, `byteenable`, `resp_rdata_o` become 0.
  - `req_ready_o` is 0 while `reset_n_i`=0.
- Reset in the middle of ACCESS abandons the bus cycle: `read`/`write` are 0 after that edge.
- Aligned access with `waitrequest` held 0:
  - Accept at edge E.
  - `read`/`write` high during cycle E+1.
  - `resp_valid_o` high during cycle E+2.
- Each stall cycle adds one cycle of latency.
- Misaligned access: `resp_valid_o` is high in the cycle after acceptance.
- Back-to-back: a request accepted in RESP is on the bus in the next cycle, giving one transfer every 2 cycles at zero wait.
- `read` and `write` are never both 1.
- All outputs are registered except `req_ready_o`, which is decoded from the state.

## Structure
- Add to `codes` package:
  - `mem_size_t` (SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2).
  - `mau_state_t` (MAU_IDLE, MAU_ACCESS, MAU_RESP).
- One combinational sub-module, `byte_lane_align`. Its parameter is `BIG_ENDIAN`.
  - Store path: produces `byteenable` and `writedata` from size, offset and wdata.
  - Load path: produces the extended result from size, offset, signed flag and `readdata`.
- The FSM, wait counter and registers live in `mem_access_unit`.

## Test plan
- LW at 0x1000, `readdata`=0x44332211, no stall, `BIG_ENDIAN`=1:
  - `address`=0x1000 and `byteenable`=4'hF for 1 cycle.
  - `resp_rdata_o`=0x11223344 two cycles after acceptance.
- LB signed at 0x1003, `readdata`=0x80000000 → `byteenable`=4'b1000, `resp_rdata_o`=0xFFFFFF80. The same access unsigned → 0x00000080.
- SH at 0x2002, wdata 0x0000ABCD, `BIG_ENDIAN`=1:
  - `address`=0x2000, `byteenable`=4'b1100, `writedata`=0xCDAB0000.
  - Then `BIG_ENDIAN`=0: `writedata`=0xABCD0000.
- LW at 0x1000 with `waitrequest` high for 3 cycles → `read` held 4 cycles with stable address, and `resp_valid_o` 5 cycles after acceptance.
- LW at 0x1001 → no `read`/`write`; the next cycle shows `resp_valid_o`=1, `resp_err_o`=1, `resp_rdata_o`=0.
- Two further cases:
  - `TIMEOUT_CYCLES`=4 with `waitrequest` stuck at 1 → `read` drops after 4 cycles and `resp_err_o`=1.
  - `reset_n_i`=0 during ACCESS → `read`=0 and state IDLE after the edge.

Source files
------------

// File: rtl/codes.sv
// Shared encodings for the load/store bus unit: access sizes, FSM states and
// small helpers for lane arithmetic and alignment.
package codes;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    MAU_IDLE   = 2'd0,
    MAU_ACCESS = 2'd1,
    MAU_RESP   = 2'd2
  } mau_state_t;

  // Index of the last byte of an access: 0 for byte, 1 for half, 3 for word.
  function automatic logic [1:0] size_last(input mem_size_t s);
    case (s)
      SIZE_HALF: size_last = 2'd1;
      SIZE_WORD: size_last = 2'd3;
      default:   size_last = 2'd0;
    endcase
  endfunction

  function automatic logic is_aligned(input mem_size_t s, input logic [1:0] o);
    case (s)
      SIZE_HALF: is_aligned = ~o[0];
      SIZE_WORD: is_aligned = (o == 2'd0);
      default:   is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering: store value -> bus lanes, bus lanes ->
// extended load value. Byte k of an access (k=0 lowest address) rides lane o+k.
module byte_lane_align
  import codes::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  mem_size_t   st_size_i,
  input  logic [1:0]  st_offset_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  mem_size_t   ld_size_i,
  input  logic [1:0]  ld_offset_i,
  input  logic        ld_signed_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_result_o
);

  logic [1:0]  w_st_last;
  logic [1:0]  w_ld_last;
  logic [31:0] w_val;

  assign w_st_last = size_last(st_size_i);
  assign w_ld_last = size_last(ld_size_i);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_st_lane
    logic [1:0] w_k;
    logic [1:0] w_j;
    assign w_k = 2'(gi) - st_offset_i;
    assign st_be_o[gi] = (2'(gi) >= st_offset_i) && (w_k <= w_st_last);
    // Big-endian puts the value's most significant byte at the lowest address.
    assign w_j = BIG_ENDIAN ? (w_st_last - w_k) : w_k;
    assign st_wdata_o[8*gi +: 8] = st_be_o[gi] ? st_wdata_i[8*w_j +: 8] : 8'h00;
  end

  for (gi = 0; gi < 4; gi++) begin : g_ld_byte
    logic [1:0] w_k;
    logic [1:0] w_lane;
    assign w_k    = BIG_ENDIAN ? (w_ld_last - 2'(gi)) : 2'(gi);
    assign w_lane = ld_offset_i + w_k;
    assign w_val[8*gi +: 8] = (2'(gi) <= w_ld_last) ? ld_rdata_i[8*w_lane +: 8] : 8'h00;
  end

  always_comb begin
    case (ld_size_i)
      SIZE_BYTE: ld_result_o = {{24{ld_signed_i & w_val[7]}}, w_val[7:0]};
      SIZE_HALF: ld_result_o = {{16{ld_signed_i & w_val[15]}}, w_val[15:0]};
      default:   ld_result_o = w_val;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit owning the Avalon-MM master port: one request in flight,
// waitrequest stalls, optional stall timeout, misalignment reported as error.
module mem_access_unit
  import codes::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  mem_size_t             req_size_i,
  input  logic                  req_signed_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  output logic                  write,
  input  logic                  waitrequest,
  output logic [31:0]           writedata,
  output logic [3:0]            byteenable,
  input  logic [31:0]           readdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  mau_state_t            r_state, w_state_next;
  logic [CW-1:0]         r_wait;
  mem_size_t             r_size;
  logic                  r_signed;
  logic [1:0]            r_off;
  logic                  r_read, r_write, r_resp_valid, r_resp_err;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata, r_resp_rdata;

  logic                  w_read_next, w_write_next, w_resp_valid_next, w_resp_err_next;
  logic [ADDR_WIDTH-1:0] w_address_next;
  logic [3:0]            w_be_next, w_st_be;
  logic [31:0]           w_wdata_next, w_resp_rdata_next, w_st_wdata, w_ld_result;
  logic                  w_accept, w_aligned, w_done, w_timeout;

  assign req_ready_o = reset_n_i && (r_state != MAU_ACCESS);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_aligned   = is_aligned(req_size_i, req_addr_i[1:0]);
  assign w_done      = (r_state == MAU_ACCESS) && !waitrequest;
  // r_wait counts stalled edges already seen; the Nth stalled edge aborts.
  assign w_timeout   = (TIMEOUT_CYCLES > 0) && (r_state == MAU_ACCESS) && waitrequest &&
                       (r_wait == CW'(TIMEOUT_CYCLES - 1));

  byte_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .st_size_i   (req_size_i),
    .st_offset_i (req_addr_i[1:0]),
    .st_wdata_i  (req_wdata_i),
    .st_be_o     (w_st_be),
    .st_wdata_o  (w_st_wdata),
    .ld_size_i   (r_size),
    .ld_offset_i (r_off),
    .ld_signed_i (r_signed),
    .ld_rdata_i  (readdata),
    .ld_result_o (w_ld_result)
  );

  always_ff @(posedge clk) begin
    if (!reset_n_i) r_state <= MAU_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MAU_ACCESS: if (w_done || w_timeout) w_state_next = MAU_RESP;
      default: begin
        if (w_accept) w_state_next = w_aligned ? MAU_ACCESS : MAU_RESP;
        else          w_state_next = MAU_IDLE;
      end
    endcase
  end

  always_comb begin
    w_read_next       = r_read;
    w_write_next      = r_write;
    w_address_next    = r_address;
    w_be_next         = r_be;
    w_wdata_next      = r_wdata;
    w_resp_valid_next = 1'b0;
    w_resp_err_next   = 1'b0;
    w_resp_rdata_next = r_resp_rdata;
    case (r_state)
      MAU_ACCESS: begin
        if (w_done || w_timeout) begin
          w_read_next       = 1'b0;
          w_write_next      = 1'b0;
          w_resp_valid_next = 1'b1;
          w_resp_err_next   = w_timeout;
          w_resp_rdata_next = (w_done && !r_write) ? w_ld_result : 32'h0;
        end
      end
      default: begin
        if (w_accept && w_aligned) begin
          w_read_next    = !req_write_i;
          w_write_next   = req_write_i;
          w_address_next = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
          w_be_next      = w_st_be;
          w_wdata_next   = req_write_i ? w_st_wdata : 32'h0;
        end else if (w_accept) begin
          w_resp_valid_next = 1'b1;
          w_resp_err_next   = 1'b1;
          w_resp_rdata_next = 32'h0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= '0;
      r_be         <= 4'h0;
      r_wdata      <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_wait       <= '0;
      r_size       <= SIZE_BYTE;
      r_signed     <= 1'b0;
      r_off        <= 2'd0;
    end else begin
      r_read       <= w_read_next;
      r_write      <= w_write_next;
      r_address    <= w_address_next;
      r_be         <= w_be_next;
      r_wdata      <= w_wdata_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_err   <= w_resp_err_next;
      r_resp_rdata <= w_resp_rdata_next;
      if (w_accept && w_aligned) begin
        r_wait   <= '0;
        r_size   <= req_size_i;
        r_signed <= req_signed_i;
        r_off    <= req_addr_i[1:0];
      end else if (r_state == MAU_ACCESS && waitrequest) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  assign read         = r_read;
  assign write        = r_write;
  assign address      = r_address;
  assign byteenable   = r_be;
  assign writedata    = r_wdata;
  assign resp_valid_o = r_resp_valid;
  assign resp_err_o   = r_resp_err;
  assign resp_rdata_o = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (big-endian, little-endian,
// big-endian with 4-cycle timeout) share one stimulus stream.
module tb_mem_access_unit;
  import codes::*;

  typedef struct {
    logic        wr;
    mem_size_t   size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd_be;
    logic [31:0] wd_le;
    logic [31:0] rd_be;
    logic [31:0] rd_le;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, req_valid, req_write, req_signed, waitrequest;
  mem_size_t   req_size;
  logic [31:0] req_addr, req_wdata, readdata;

  logic        rdy [3];
  logic        rv  [3];
  logic        rerr[3];
  logic        rd  [3];
  logic        wr  [3];
  logic [31:0] rres[3];
  logic [31:0] addr[3];
  logic [31:0] wd  [3];
  logic [3:0]  be  [3];

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    mem_access_unit #(
      .ADDR_WIDTH     (32),
      .BIG_ENDIAN     (gi != 1),
      .TIMEOUT_CYCLES ((gi == 2) ? 4 : 0)
    ) u_dut (
      .clk          (clk),
      .reset_n_i    (reset_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (rdy[gi]),
      .req_write_i  (req_write),
      .req_size_i   (req_size),
      .req_signed_i (req_signed),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (rv[gi]),
      .resp_rdata_o (rres[gi]),
      .resp_err_o   (rerr[gi]),
      .address      (addr[gi]),
      .read         (rd[gi]),
      .write        (wr[gi]),
      .waitrequest  (waitrequest),
      .writedata    (wd[gi]),
      .byteenable   (be[gi]),
      .readdata     (readdata)
    );
  end

  int  n_tests = 0;
  int  n_fail  = 0;
  sb_t q_be[$];
  sb_t q_le[$];
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response scoreboard for the two non-timeout instances.
  always @(negedge clk) begin : mon
    sb_t e;
    if (reset_n && rv[0]) begin
      check("le_valid_with_be", {31'd0, rv[1]}, 32'd1);
      if (q_be.size() == 0 || q_le.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata %h err %0d expected no response", rres[0], rerr[0]);
      end else begin
        e = q_be.pop_front();
        check("resp_rdata_be", rres[0], e.rdata);
        check("resp_err_be", {31'd0, rerr[0]}, {31'd0, e.err});
        e = q_le.pop_front();
        check("resp_rdata_le", rres[1], e.rdata);
        check("resp_err_le", {31'd0, rerr[1]}, {31'd0, e.err});
        $display("[TB] resp rdata_be=%h rdata_le=%h err=%0d", rres[0], rres[1], rerr[0]);
      end
    end
  end

  task automatic drive(input logic w, input mem_size_t s, input logic sg,
                       input logic [31:0] a, input logic [31:0] wdat, input logic [31:0] rdat);
    req_valid = 1'b1;
    req_write = w;
    req_size  = s;
    req_signed = sg;
    req_addr  = a;
    req_wdata = wdat;
    readdata  = rdat;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    drive(v.wr, v.size, v.sgn, v.addr, v.wdata, v.rdata);
    waitrequest = 1'b0;
    check($sformatf("v%0d_ready", i), {31'd0, rdy[0]}, 32'd1);
    q_be.push_back('{v.rd_be, v.err});
    q_le.push_back('{v.rd_le, v.err});
    $display("[TB] vec %0d wr=%0d size=%0d addr=%h", i, v.wr, v.size, v.addr);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.err) begin
      check($sformatf("v%0d_no_bus", i), {30'd0, rd[0], wr[0]}, 32'd0);
    end else begin
      check($sformatf("v%0d_rw", i), {30'd0, rd[0], wr[0]}, v.wr ? 32'd1 : 32'd2);
      check($sformatf("v%0d_addr", i), addr[0], v.addr & 32'hFFFF_FFFC);
      check($sformatf("v%0d_be", i), {28'd0, be[0]}, {28'd0, v.be});
      if (v.wr) begin
        check($sformatf("v%0d_wd_be", i), wd[0], v.wd_be);
        check($sformatf("v%0d_wd_le", i), wd[1], v.wd_le);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n_hi;
    logic got;

    vecs[0]  = '{1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h0, 32'h44332211, 4'hF, 32'h0, 32'h0, 32'h11223344, 32'h44332211, 1'b0};
    vecs[1]  = '{1'b0, SIZE_BYTE, 1'b1, 32'h1003, 32'h0, 32'h80000000, 4'h8, 32'h0, 32'h0, 32'hFFFFFF80, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, SIZE_BYTE, 1'b0, 32'h1003, 32'h0, 32'h80000000, 4'h8, 32'h0, 32'h0, 32'h00000080, 32'h00000080, 1'b0};
    vecs[3]  = '{1'b1, SIZE_HALF, 1'b0, 32'h2002, 32'h0000ABCD, 32'h0, 4'hC, 32'hCDAB0000, 32'hABCD0000, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, SIZE_HALF, 1'b1, 32'h1000, 32'h0, 32'h12348001, 4'h3, 32'h0, 32'h0, 32'h00000180, 32'hFFFF8001, 1'b0};
    vecs[5]  = '{1'b0, SIZE_HALF, 1'b0, 32'h1002, 32'h0, 32'h12348001, 4'hC, 32'h0, 32'h0, 32'h00003412, 32'h00001234, 1'b0};
    vecs[6]  = '{1'b1, SIZE_BYTE, 1'b0, 32'h3001, 32'hFFFFFF5A, 32'h0, 4'h2, 32'h00005A00, 32'h00005A00, 32'h0, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, SIZE_WORD, 1'b0, 32'h3000, 32'hDEADBEEF, 32'h0, 4'hF, 32'hEFBEADDE, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, SIZE_WORD, 1'b0, 32'h1001, 32'h0, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, SIZE_HALF, 1'b1, 32'h1003, 32'h0, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[10] = '{1'b1, SIZE_WORD, 1'b0, 32'h2002, 32'h12345678, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b0, SIZE_BYTE, 1'b1, 32'h1001, 32'h0, 32'h00007F00, 4'h2, 32'h0, 32'h0, 32'h0000007F, 32'h0000007F, 1'b0};
    vecs[12] = '{1'b0, SIZE_HALF, 1'b1, 32'h1002, 32'h0, 32'h80FF0000, 4'hC, 32'h0, 32'h0, 32'hFFFFFF80, 32'hFFFF80FF, 1'b0};

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SIZE_BYTE;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; readdata = 32'h0; waitrequest = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, rdy[0]}, 32'd0);
    check("rst_ctrl", {28'd0, rd[0], wr[0], rv[0], rerr[0]}, 32'd0);
    check("rst_addr", addr[0], 32'd0);
    check("rst_wdata_be", {wd[0][27:0], be[0]}, 32'd0);
    check("rst_rdata", rres[0], 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Three stalled edges: read held four cycles, response in the fifth.
    @(negedge clk);
    drive(1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h0, 32'h44332211);
    waitrequest = 1'b1;
    q_be.push_back('{32'h11223344, 1'b0});
    q_le.push_back('{32'h44332211, 1'b0});
    $display("[TB] stall LW addr=00001000");
    n_hi = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rd[0] && addr[0] == 32'h1000 && be[0] == 4'hF) n_hi++;
      if (c == 4) waitrequest = 1'b0;
    end
    check("stall_read_cycles", n_hi, 4);
    @(negedge clk);
    check("stall_resp_valid", {31'd0, rv[0]}, 32'd1);
    check("stall_read_low", {31'd0, rd[0]}, 32'd0);
    check("stall_no_timeout", {30'd0, rv[2], rerr[2]}, 32'd2);
    check("stall_t4_rdata", rres[2], 32'h11223344);

    // Stuck waitrequest: only the timeout instance gives up.
    @(negedge clk);
    drive(1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h0, 32'h55555555);
    waitrequest = 1'b1;
    $display("[TB] timeout LW addr=00001000");
    n_hi = 0;
    got  = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rd[2]) n_hi++;
      else if (rv[2]) begin
        got = 1'b1;
        check("to_err", {31'd0, rerr[2]}, 32'd1);
        check("to_rdata", rres[2], 32'd0);
      end
    end
    check("to_read_cycles", n_hi, 4);
    check("to_resp_seen", {31'd0, got}, 32'd1);

    // Reset while the non-timeout instances are still in ACCESS.
    check("pre_rst_read", {31'd0, rd[0]}, 32'd1);
    reset_n = 1'b0;
    $display("[TB] reset during access");
    @(negedge clk);
    check("mid_rst_ctrl", {27'd0, rd[0], wr[0], rv[0], rd[1], rdy[0]}, 32'd0);
    check("mid_rst_addr_be", {addr[0][27:0], be[0]}, 32'd0);
    reset_n = 1'b1;
    waitrequest = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {30'd0, rdy[0], rd[0]}, 32'd2);

    // Back-to-back: second request accepted in RESP, on the bus next cycle.
    drive(1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'h0, 32'hA1B2C3D4);
    q_be.push_back('{32'hD4C3B2A1, 1'b0});
    q_le.push_back('{32'hA1B2C3D4, 1'b0});
    $display("[TB] b2b LW 00001000 then 00001004");
    @(negedge clk);
    check("b2b_busy", {31'd0, rdy[0]}, 32'd0);
    req_addr = 32'h1004;
    q_be.push_back('{32'h04030201, 1'b0});
    q_le.push_back('{32'h01020304, 1'b0});
    @(negedge clk);
    check("b2b_ready_resp", {30'd0, rdy[0], rv[0]}, 32'd3);
    readdata = 32'h01020304;
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_read_b", {31'd0, rd[0]}, 32'd1);
    check("b2b_addr_b", addr[0], 32'h1004);
    @(negedge clk);
    check("b2b_resp_b", {31'd0, rv[0]}, 32'd1);

    repeat (3) @(negedge clk);
    check("sb_empty", q_be.size() + q_le.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
